ps2_rx_frame: RTL and testbench

- Upstream receiver stage of the keyboard path. It deserialises the raw PS/2 clock/data lines into 8-bit scan-code bytes.
- Each good byte produces a one-cycle `rx_done_tick` with the byte held on `dout`. These feed the scan-code/break-code (F0) decoder's `ready`/`datain` inputs directly.
- The block filters line glitches, checks start/stop/odd parity, and aborts stalled frames on timeout.

---
 rtl/ps2_rx_frame.sv | 152 +++++++++++++++
 tb/tb_ps2_rx_frame.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/ps2_rx_frame.sv
// PS/2 receive framer: synchronises and de-glitches the raw PS/2 clock/data
// lines, shifts in 11-bit frames on filtered falling clock edges, and emits
// one good byte per rx_done_tick or a single err_tick for a bad/stalled frame.
//
// Handshake: rx_done_tick is a one-cycle valid strobe with no ready; dout is
// valid in the strobe cycle and held until the next good frame. err_tick is a
// one-cycle strobe that never coincides with rx_done_tick.
module ps2_rx_frame #(
  parameter int FILTER_LEN  = 8,
  parameter int TIMEOUT_CYC = 100000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       ps2c,
  input  logic       ps2d,
  input  logic       rx_en,
  output logic [7:0] dout,
  output logic       rx_done_tick,
  output logic       err_tick,
  output logic       busy
);

  localparam int TW = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT_CYC - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    CHECK = 2'd2
  } state_t;

  logic                  c_s1, c_s2, d_s1, d_s2;
  logic [FILTER_LEN-1:0] filt;
  logic                  fc, fc_next, fall_tick;

  state_t                state, state_next;
  logic [3:0]            n, n_next;
  logic [10:0]           sh, sh_next;
  logic [TW-1:0]         tcnt, tcnt_next;
  logic [7:0]            dout_next;
  logic                  done_next, err_next;

  // Two-flop synchronisers for the asynchronous PS/2 lines (idle high).
  always_ff @(posedge clk) begin
    if (!reset) begin
      c_s1 <= 1'b1;
      c_s2 <= 1'b1;
      d_s1 <= 1'b1;
      d_s2 <= 1'b1;
    end else begin
      c_s1 <= ps2c;
      c_s2 <= c_s1;
      d_s1 <= ps2d;
      d_s2 <= d_s1;
    end
  end

  // Filtered clock level: switches only after FILTER_LEN identical samples.
  always_comb begin
    fc_next = fc;
    if (&filt)
      fc_next = 1'b1;
    else if (~|filt)
      fc_next = 1'b0;
  end

  // Filter shift register, filtered level and registered falling-edge pulse.
  always_ff @(posedge clk) begin
    if (!reset) begin
      filt      <= '1;
      fc        <= 1'b1;
      fall_tick <= 1'b0;
    end else begin
      filt      <= {filt[FILTER_LEN-2:0], c_s2};
      fc        <= fc_next;
      fall_tick <= fc & ~fc_next;
    end
  end

  // Frame FSM next-state, shift/count updates and output strobes.
  always_comb begin
    state_next = state;
    n_next     = n;
    sh_next    = sh;
    tcnt_next  = tcnt;
    dout_next  = dout;
    done_next  = 1'b0;
    err_next   = 1'b0;
    case (state)
      IDLE: begin
        // A start bit is a low data line at a filtered falling edge.
        if (fall_tick && rx_en && !d_s2) begin
          sh_next    = {1'b0, sh[10:1]};
          n_next     = 4'd10;
          tcnt_next  = '0;
          state_next = SHIFT;
        end
      end
      SHIFT: begin
        if (fall_tick) begin
          sh_next   = {d_s2, sh[10:1]};
          n_next    = n - 4'd1;
          tcnt_next = '0;
          if (n == 4'd1)
            state_next = CHECK;
        end else if (tcnt == T_LAST) begin
          // Stalled frame: drop it without touching dout.
          err_next   = 1'b1;
          tcnt_next  = '0;
          state_next = IDLE;
        end else begin
          tcnt_next = tcnt + 1'b1;
        end
      end
      CHECK: begin
        // sh[0]=start, sh[8:1]=data, sh[9]=parity, sh[10]=stop; odd parity.
        state_next = IDLE;
        if (!sh[0] && sh[10] && (^sh[9:1])) begin
          dout_next = sh[8:1];
          done_next = 1'b1;
        end else begin
          err_next = 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Frame FSM state, shift register, counters and registered outputs.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state        <= IDLE;
      n            <= 4'd0;
      sh           <= '0;
      tcnt         <= '0;
      dout         <= 8'h00;
      rx_done_tick <= 1'b0;
      err_tick     <= 1'b0;
    end else begin
      state        <= state_next;
      n            <= n_next;
      sh           <= sh_next;
      tcnt         <= tcnt_next;
      dout         <= dout_next;
      rx_done_tick <= done_next;
      err_tick     <= err_next;
    end
  end

  assign busy = (state != IDLE);

endmodule

// File: tb/tb_ps2_rx_frame.sv
// Bench for ps2_rx_frame: drives PS/2 frames on the raw lines, keeps a
// frame-level model of the receiver, and compares all outputs every cycle.
module tb_ps2_rx_frame;

  localparam int FL       = 8;
  localparam int TO       = 2500;
  localparam int FALL_LAT = FL + 3;   // raw ps2c fall -> filtered fall cycle

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       ps2c = 1'b1;
  logic       ps2d = 1'b1;
  logic       rx_en = 1'b1;
  logic [7:0] dout;
  logic       rx_done_tick, err_tick, busy;

  int total = 0;
  int bad = 0;
  int cyc = 0;

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  logic rst_q;
  always @(posedge clk) rst_q <= reset;

  ps2_rx_frame #(.FILTER_LEN(FL), .TIMEOUT_CYC(TO)) dut (
    .clk(clk), .reset(reset), .ps2c(ps2c), .ps2d(ps2d), .rx_en(rx_en),
    .dout(dout), .rx_done_tick(rx_done_tick), .err_tick(err_tick), .busy(busy)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      if (bad <= 20)
        $display("FAIL %s cyc=%0d got=%0h want=%0h", name, cyc, act, exp);
    end
  endtask

  // ---------------- model ----------------
  typedef struct {
    int   t;
    logic b;
  } fall_t;
  fall_t      fall_q[$];
  logic [7:0] exp_q[$];

  bit          active = 0;
  int          nb = 0;
  logic [10:0] fr = '0;
  int          last_fall = 0;
  int          busy_on_cyc = -1;
  int          res_cyc = -1;
  bit          res_ok = 0;
  bit          exp_busy = 0;
  bit          exp_done = 0;
  bit          exp_err = 0;
  logic [7:0]  exp_dout = 8'h00;
  fall_t       f;

  int          n_done = 0;
  int          n_err = 0;
  bit          brk = 0;
  logic [7:0]  key_out = 8'h00;

  // Frame-level model update and per-cycle compare of every output.
  always @(negedge clk) begin
    if (cyc >= 1) begin
      exp_done = 0;
      exp_err  = 0;
      if (!rst_q) begin
        active = 0; exp_busy = 0; exp_dout = 8'h00;
        fall_q.delete(); exp_q.delete();
        busy_on_cyc = -1; res_cyc = -1;
      end else begin
        if (busy_on_cyc == cyc) begin
          exp_busy = 1; busy_on_cyc = -1;
        end
        if (res_cyc == cyc) begin
          exp_busy = 0; res_cyc = -1;
          if (res_ok) begin
            exp_done = 1;
            exp_dout = exp_q.pop_front();
          end else begin
            exp_err = 1;
          end
        end
        if (active && cyc == last_fall + TO + 1) begin
          active = 0; exp_busy = 0; exp_err = 1;
        end
        if (fall_q.size() > 0 && fall_q[0].t == cyc) begin
          f = fall_q.pop_front();
          if (!active) begin
            if (rx_en && !f.b) begin
              active = 1; nb = 1; fr = '0; last_fall = cyc;
              busy_on_cyc = cyc + 1;
            end
          end else begin
            fr[nb] = f.b;
            nb++;
            last_fall = cyc;
            if (nb == 11) begin
              active  = 0;
              res_cyc = cyc + 2;
              res_ok  = (fr[0] == 1'b0) && (fr[10] == 1'b1) && (^fr[9:1]);
              if (res_ok) exp_q.push_back(fr[8:1]);
            end
          end
        end
      end
      check("dout", 32'(dout), 32'(exp_dout));
      check("rx_done_tick", 32'(rx_done_tick), 32'(exp_done));
      check("err_tick", 32'(err_tick), 32'(exp_err));
      check("busy", 32'(busy), 32'(exp_busy));
      // Observed pulse counters and a tiny break-code (F0) decoder.
      if (rx_done_tick === 1'b1) begin
        n_done++;
        if (dout == 8'hF0) begin
          brk = 1;
        end else begin
          if (brk) key_out = dout;
          brk = 0;
        end
      end
      if (err_tick === 1'b1) n_err++;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic wait_cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  function automatic logic [10:0] mk(input logic [7:0] d, input logic par_flip, input logic stop);
    return {stop, (~^d) ^ par_flip, d, 1'b0};
  endfunction

  task automatic send_range(input logic [10:0] frm, input int lo, input int hi, input int half);
    fall_t e;
    for (int i = lo; i <= hi; i++) begin
      ps2d = frm[i];
      wait_cyc(half);
      ps2c = 1'b0;
      e.t = cyc + FALL_LAT;
      e.b = frm[i];
      fall_q.push_back(e);
      wait_cyc(half);
      ps2c = 1'b1;
    end
  endtask

  task automatic send_frame(input logic [10:0] frm, input int half);
    send_range(frm, 0, 10, half);
    ps2d = 1'b1;
    wait_cyc(50);
  endtask

  // ---------------- directed stimulus ----------------
  initial begin
    reset = 1'b0;
    wait_cyc(5);
    reset = 1'b1;
    wait_cyc(20);
    check("reset_dout", 32'(dout), 32'h00);
    check("reset_busy", 32'(busy), 32'h0);
    check("frame_1c_bits", 32'(mk(8'h1C, 1'b0, 1'b1)), 32'h438);
    check("frame_f0_bits", 32'(mk(8'hF0, 1'b0, 1'b1)), 32'h7E0);

    // good 0x1C at a 2000-cycle PS/2 clock period
    send_frame(mk(8'h1C, 1'b0, 1'b1), 1000);
    check("good_1c_dout", 32'(dout), 32'h1C);
    check("good_1c_done", 32'(n_done), 32'd1);
    check("good_1c_err", 32'(n_err), 32'd0);

    // break sequence F0 then 1C
    send_frame(mk(8'hF0, 1'b0, 1'b1), 100);
    send_frame(mk(8'h1C, 1'b0, 1'b1), 100);
    check("break_key", 32'(key_out), 32'h1C);
    check("break_done", 32'(n_done), 32'd3);

    // bad parity, then bad stop bit
    send_frame(mk(8'h1C, 1'b1, 1'b1), 100);
    check("par_err_cnt", 32'(n_err), 32'd1);
    check("par_err_done", 32'(n_done), 32'd3);
    check("par_err_dout", 32'(dout), 32'h1C);
    send_frame(mk(8'h1C, 1'b0, 1'b0), 100);
    check("stop_err_cnt", 32'(n_err), 32'd2);
    check("stop_err_dout", 32'(dout), 32'h1C);

    // short glitch on the clock line is filtered out
    ps2c = 1'b0;
    wait_cyc(3);
    ps2c = 1'b1;
    wait_cyc(50);
    check("glitch_busy", 32'(busy), 32'h0);
    check("glitch_err", 32'(n_err), 32'd2);
    check("glitch_done", 32'(n_done), 32'd3);

    // stalled frame times out, then a good 0x5A
    send_range(mk(8'h5A, 1'b0, 1'b1), 0, 4, 100);
    ps2d = 1'b1;
    wait_cyc(TO + 100);
    check("timeout_err", 32'(n_err), 32'd3);
    check("timeout_busy", 32'(busy), 32'h0);
    send_frame(mk(8'h5A, 1'b0, 1'b1), 100);
    check("after_to_dout", 32'(dout), 32'h5A);
    check("after_to_done", 32'(n_done), 32'd4);

    // reset after six data bits; the rest of that frame is all ones
    send_range(mk(8'hC0, 1'b0, 1'b1), 0, 6, 100);
    wait_cyc(50);
    reset = 1'b0;
    wait_cyc(1);
    reset = 1'b1;
    check("midrst_dout", 32'(dout), 32'h00);
    check("midrst_busy", 32'(busy), 32'h0);
    send_range(mk(8'hC0, 1'b0, 1'b1), 7, 10, 100);
    wait_cyc(50);
    check("midrst_done", 32'(n_done), 32'd4);
    check("midrst_err", 32'(n_err), 32'd3);
    send_frame(mk(8'h29, 1'b0, 1'b1), 100);
    check("after_rst_dout", 32'(dout), 32'h29);
    check("after_rst_done", 32'(n_done), 32'd5);

    // rx_en low: whole frame ignored
    rx_en = 1'b0;
    wait_cyc(20);
    send_frame(mk(8'h1C, 1'b0, 1'b1), 100);
    check("rxen_off_done", 32'(n_done), 32'd5);
    check("rxen_off_err", 32'(n_err), 32'd3);
    check("rxen_off_dout", 32'(dout), 32'h29);

    // rx_en dropped mid-frame does not abort it
    rx_en = 1'b1;
    wait_cyc(20);
    send_range(mk(8'h32, 1'b0, 1'b1), 0, 3, 100);
    rx_en = 1'b0;
    send_range(mk(8'h32, 1'b0, 1'b1), 4, 10, 100);
    ps2d = 1'b1;
    wait_cyc(50);
    rx_en = 1'b1;
    check("rxen_mid_dout", 32'(dout), 32'h32);
    check("rxen_mid_done", 32'(n_done), 32'd6);
    check("rxen_mid_err", 32'(n_err), 32'd3);
    check("end_busy", 32'(busy), 32'h0);

    wait_cyc(10);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
